spi_xfer_seq: RTL and testbench

SPI_XFER_SEQ -- requirements
Module: spi_xfer_seq

---
 rtl/spi_xfer_seq.sv | 182 ++++++++++++++++++
 tb/tb_spi_xfer_seq.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_seq.sv
// Word sequencer between a host stream pair and a single-word SPI core.
// TX words are buffered, strobed one at a time into the core under one ss_n burst, and results are buffered for the host.
module spi_xfer_seq #(
  parameter int DWIDTH  = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DWIDTH-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              core_cs,
  output logic              core_wr,
  output logic              core_rd,
  output logic [DWIDTH-1:0] core_din,
  input  logic [DWIDTH-1:0] core_dout,
  input  logic              core_done,
  output logic              ss_n,
  output logic              busy,
  output logic              err,
  input  logic              err_clr,
  output logic [2:0]        dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_STROBE, ST_WAIT, ST_CAPTURE, ST_HOLD
  } state_t;

  state_t            r_state;
  logic              r_ss_n;
  logic              r_core_cs;
  logic              r_core_wr;
  logic [DWIDTH-1:0] r_core_din;
  logic              r_busy;
  logic              r_err;
  logic [TW-1:0]     r_timer;
  logic              r_done_q;

  logic [DWIDTH-1:0] r_tx_mem [DEPTH];
  logic [AW-1:0]     r_tx_wptr, r_tx_rptr;
  logic [CW-1:0]     r_tx_cnt;
  logic [DWIDTH-1:0] r_rx_mem [DEPTH];
  logic [AW-1:0]     r_rx_wptr, r_rx_rptr;
  logic [CW-1:0]     r_rx_cnt;

  logic          w_tx_ready, w_tx_push, w_tx_pop;
  logic          w_rx_valid, w_rx_push, w_rx_pop;
  logic [CW-1:0] w_rx_cnt_after;
  logic [TW-1:0] w_timer_inc;
  logic          w_edge;

  assign w_tx_ready = (r_tx_cnt < CW'(DEPTH));
  assign w_tx_push  = tx_valid & w_tx_ready;
  assign w_tx_pop   = (r_state == ST_STROBE);
  assign w_rx_valid = (r_rx_cnt != '0);
  assign w_rx_pop   = rx_ready & w_rx_valid;
  assign w_rx_push  = (r_state == ST_CAPTURE);
  // RX occupancy once this cycle's capture and any host read have both landed.
  assign w_rx_cnt_after = r_rx_cnt + CW'(1) - (w_rx_pop ? CW'(1) : CW'(0));
  assign w_timer_inc    = r_timer + TW'(1);
  assign w_edge         = core_done & ~r_done_q;

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= tx_data;
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= core_dout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
      r_tx_cnt  <= '0;
      r_rx_wptr <= '0;
      r_rx_rptr <= '0;
      r_rx_cnt  <= '0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + AW'(1);
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + AW'(1);
      if (w_tx_push && !w_tx_pop) r_tx_cnt <= r_tx_cnt + CW'(1);
      else if (!w_tx_push && w_tx_pop) r_tx_cnt <= r_tx_cnt - CW'(1);
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + AW'(1);
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + AW'(1);
      if (w_rx_push && !w_rx_pop) r_rx_cnt <= r_rx_cnt + CW'(1);
      else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - CW'(1);
    end
  end

  // Outputs are registered alongside the state, so each is set on entry to the state that owns it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ss_n     <= 1'b1;
      r_core_cs  <= 1'b0;
      r_core_wr  <= 1'b0;
      r_core_din <= '0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_timer    <= '0;
      r_done_q   <= 1'b0;
    end else begin
      r_core_cs  <= 1'b0;
      r_core_wr  <= 1'b0;
      r_core_din <= '0;
      if (err_clr) r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_tx_cnt != '0 && r_rx_cnt < CW'(DEPTH)) begin
            r_state <= ST_SETUP;
            r_ss_n  <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        ST_SETUP: begin
          r_state    <= ST_STROBE;
          r_core_cs  <= 1'b1;
          r_core_wr  <= 1'b1;
          r_core_din <= r_tx_mem[r_tx_rptr];
        end
        ST_STROBE: begin
          // Seed done_q so a done level still high from the previous word is not an edge.
          r_state  <= ST_WAIT;
          r_timer  <= '0;
          r_done_q <= core_done;
        end
        ST_WAIT: begin
          r_done_q <= core_done;
          if (w_edge) begin
            r_state <= ST_CAPTURE;
          end else if (w_timer_inc == TW'(TIMEOUT)) begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
            r_ss_n  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_timer <= w_timer_inc;
          end
        end
        ST_CAPTURE: begin
          if (r_tx_cnt != '0 && w_rx_cnt_after < CW'(DEPTH)) begin
            r_state    <= ST_STROBE;
            r_core_cs  <= 1'b1;
            r_core_wr  <= 1'b1;
            r_core_din <= r_tx_mem[r_tx_rptr];
          end else begin
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          r_state <= ST_IDLE;
          r_ss_n  <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ss_n  <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready  = w_tx_ready;
  assign rx_valid  = w_rx_valid;
  assign rx_data   = r_rx_mem[r_rx_rptr];
  assign core_cs   = r_core_cs;
  assign core_wr   = r_core_wr;
  assign core_rd   = 1'b0;
  assign core_din  = r_core_din;
  assign ss_n      = r_ss_n;
  assign busy      = r_busy;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_spi_xfer_seq.sv
// Bench for spi_xfer_seq: behavioural SPI core returning din ^ 0x99, host stream driver, RX scoreboard.
`timescale 1ns/1ps
module tb_spi_xfer_seq;

  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int TIMEOUT = 10;
  localparam logic [2:0] SETUP_ST = 3'd1;
  localparam logic [2:0] HOLD_ST  = 3'd5;

  logic          clk, rst;
  logic [DW-1:0] tx_data;
  logic          tx_valid, tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid, rx_ready;
  logic          core_cs, core_wr, core_rd;
  logic [DW-1:0] core_din, core_dout;
  logic          core_done;
  logic          ss_n, busy, err, err_clr;
  logic [2:0]    dbg_state;

  spi_xfer_seq #(.DWIDTH(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .core_cs(core_cs), .core_wr(core_wr), .core_rd(core_rd), .core_din(core_din),
    .core_dout(core_dout), .core_done(core_done),
    .ss_n(ss_n), .busy(busy), .err(err), .err_clr(err_clr),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] tx_q[$];
  int wr_count = 0, ss_falls = 0, hold_count = 0, rx_reads = 0;
  int rx_allow = 0;
  int core_mode = 0;   // 0 normal, 1 never done, 2 stale done level first
  int core_lat = 4;
  logic prev_ss_n = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // behavioural SPI core
  initial begin
    logic [DW-1:0] din_l;
    core_done = 1'b0;
    core_dout = '0;
    forever begin
      @(negedge clk);
      if (core_wr && core_mode != 1) begin
        din_l = core_din;
        if (core_mode == 2) begin
          repeat (2) @(negedge clk);
          core_done = 1'b0;
          repeat (3) @(negedge clk);
        end else begin
          repeat (core_lat) @(negedge clk);
        end
        core_dout = din_l ^ 8'h99;
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
      end
    end
  end

  // core-side monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (core_wr) begin
          wr_count++;
          check_eq("wr_ss_n", ss_n, 0);
          check_eq("wr_cs", core_cs, 1);
          check_eq("wr_expected", tx_q.size() > 0, 1);
          if (tx_q.size() > 0) check_eq("core_din", core_din, tx_q.pop_front());
        end
        if (prev_ss_n && !ss_n) ss_falls++;
        prev_ss_n = ss_n;
        if (dbg_state == HOLD_ST) hold_count++;
      end
    end
  end

  // host read side + scoreboard compare
  initial begin
    rx_ready = 1'b0;
    forever begin
      @(negedge clk);
      rx_ready = (rx_allow != 0) && !rst;
      if (rx_ready && rx_valid) begin
        check_eq("rx_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check_eq("rx_data", rx_data, exp_q.pop_front());
        rx_reads++;
        if (rx_allow > 0) rx_allow--;
      end
    end
  end

  // driver tasks (called at a negedge, return at a negedge)
  task automatic push_word(input logic [DW-1:0] d, input bit exp_rx);
    int n = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && n < 300) begin @(negedge clk); n++; end
    check_eq("push_ready", tx_ready, 1);
    tx_q.push_back(d);
    if (exp_rx) exp_q.push_back(d ^ 8'h99);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_wr(input int target, input int max);
    int n = 0;
    while (wr_count < target && n < max) begin @(negedge clk); n++; end
    check_eq("wait_wr", wr_count >= target, 1);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (!(busy == 1'b0 && ss_n == 1'b1) && n < max) begin @(negedge clk); n++; end
    check_eq("wait_idle", busy == 1'b0 && ss_n == 1'b1, 1);
  endtask

  task automatic wait_drained(input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin @(negedge clk); n++; end
    check_eq("wait_drained", exp_q.size(), 0);
  endtask

  initial begin
    int base, bhold, bfall, n, seen;
    rst = 1'b1; tx_valid = 1'b0; tx_data = '0; err_clr = 1'b0;
    #1;
    check_eq("rst_ss_n", ss_n, 1);
    check_eq("rst_tx_ready", tx_ready, 1);
    check_eq("rst_rx_valid", rx_valid, 0);
    check_eq("rst_core_cs", core_cs, 0);
    check_eq("rst_core_wr", core_wr, 0);
    check_eq("rst_core_din", core_din, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_err", err, 0);
    check_eq("core_rd", core_rd, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // single word with latency checks
    rx_allow = 0; core_lat = 4; bhold = hold_count;
    push_word(8'hA5, 1);
    check_eq("sw_idle_ss_n", ss_n, 1);
    @(negedge clk);
    check_eq("sw_setup_state", dbg_state, SETUP_ST);
    check_eq("sw_setup_ss_n", ss_n, 0);
    check_eq("sw_setup_wr", core_wr, 0);
    @(negedge clk);
    check_eq("sw_strobe_wr", core_wr, 1);
    check_eq("sw_strobe_din", core_din, 8'hA5);
    @(negedge clk);
    check_eq("sw_wr_single", core_wr, 0);
    check_eq("sw_din_cleared", core_din, 0);
    n = 0;
    while (!rx_valid && n < 30) begin @(negedge clk); n++; end
    check_eq("sw_rx_valid", rx_valid, 1);
    check_eq("sw_rx_data", rx_data, 8'h3C);
    check_eq("sw_hold_state", dbg_state, HOLD_ST);
    check_eq("sw_hold_ss_n", ss_n, 0);
    @(negedge clk);
    check_eq("sw_end_ss_n", ss_n, 1);
    check_eq("sw_end_busy", busy, 0);
    check_eq("sw_hold_once", hold_count - bhold, 1);
    rx_allow = -1;
    wait_drained(20);

    // back-to-back burst
    base = wr_count; bhold = hold_count; bfall = ss_falls;
    push_word(8'h01, 1);
    push_word(8'h02, 1);
    push_word(8'h03, 1);
    wait_wr(base + 3, 100);
    wait_idle(50);
    wait_drained(20);
    check_eq("burst_wr", wr_count - base, 3);
    check_eq("burst_ss_falls", ss_falls - bfall, 1);
    check_eq("burst_hold", hold_count - bhold, 1);

    // RX backpressure
    rx_allow = 0; base = wr_count;
    for (int i = 0; i < 6; i++) push_word(8'h10 + 8'(i), 1);
    wait_wr(base + 4, 200);
    wait_idle(50);
    repeat (10) @(negedge clk);
    check_eq("bp_wr4", wr_count - base, 4);
    check_eq("bp_busy", busy, 0);
    check_eq("bp_ss_n", ss_n, 1);
    check_eq("bp_rx_valid", rx_valid, 1);
    rx_allow = 1;
    wait_wr(base + 5, 50);
    wait_idle(50);
    repeat (10) @(negedge clk);
    check_eq("bp_wr5", wr_count - base, 5);
    check_eq("bp_exp_left", exp_q.size(), 5);
    rx_allow = -1;
    wait_wr(base + 6, 100);
    wait_idle(50);
    wait_drained(30);
    check_eq("bp_wr6", wr_count - base, 6);

    // timeout: core never answers
    core_mode = 1; base = rx_reads;
    push_word(8'h55, 0);
    n = 0;
    while (!core_wr && n < 20) begin @(negedge clk); n++; end
    check_eq("to_strobe_seen", core_wr, 1);
    n = 0;
    while (!err && n < 40) begin @(negedge clk); n++; end
    check_eq("to_cycles", n, TIMEOUT + 1);
    check_eq("to_ss_n", ss_n, 1);
    check_eq("to_busy", busy, 0);
    check_eq("to_rx_valid", rx_valid, 0);
    repeat (3) @(negedge clk);
    check_eq("to_sticky", err, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check_eq("to_cleared", err, 0);
    check_eq("to_no_rx", rx_reads - base, 0);

    // done edge in the final allowed cycle wins over timeout
    core_mode = 0; core_lat = TIMEOUT; base = wr_count;
    push_word(8'h66, 1);
    wait_wr(base + 1, 20);
    wait_idle(40);
    wait_drained(20);
    check_eq("edge_wins_err", err, 0);

    // one cycle later it is a timeout
    core_lat = TIMEOUT + 1; base = wr_count;
    push_word(8'h77, 0);
    wait_wr(base + 1, 20);
    wait_idle(40);
    check_eq("late_err", err, 1);
    repeat (5) @(negedge clk);
    check_eq("late_no_rx", rx_valid, 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;

    // stale done level at WAIT entry
    core_dout = 8'hEE; core_done = 1'b1; core_mode = 2;
    base = wr_count; seen = rx_reads;
    push_word(8'h5A, 1);
    wait_wr(base + 1, 20);
    wait_idle(40);
    wait_drained(20);
    repeat (5) @(negedge clk);
    check_eq("stale_wr", wr_count - base, 1);
    check_eq("stale_one_capture", rx_reads - seen, 1);
    check_eq("stale_err", err, 0);

    // asynchronous reset in the middle of WAIT
    core_mode = 0; core_lat = 8; rx_allow = 0;
    push_word(8'h81, 1);
    push_word(8'h82, 1);
    seen = 0; n = 0;
    while (seen < 2 && n < 100) begin
      @(negedge clk);
      if (core_wr) seen++;
      n++;
    end
    check_eq("rw_second_strobe", seen, 2);
    repeat (2) @(negedge clk);
    check_eq("rw_pre_rx_valid", rx_valid, 1);
    check_eq("rw_pre_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("rw_ss_n", ss_n, 1);
    check_eq("rw_tx_ready", tx_ready, 1);
    check_eq("rw_rx_valid", rx_valid, 0);
    check_eq("rw_busy", busy, 0);
    check_eq("rw_core_wr", core_wr, 0);
    exp_q.delete();
    tx_q.delete();
    base = wr_count;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check_eq("rw_no_wr", wr_count - base, 0);
    check_eq("rw_idle", busy, 0);
    rx_allow = -1; core_lat = 4;
    push_word(8'h99, 1);
    wait_wr(base + 1, 20);
    wait_idle(40);
    wait_drained(20);
    check_eq("rw_after_wr", wr_count - base, 1);

    check_eq("final_exp_q", exp_q.size(), 0);
    check_eq("final_tx_q", tx_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
